// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined multiplier family.
package mul_pkg;

  // Widest operand any instance may use; ext_operand() works at this width.
  localparam int MAX_W = 64;

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Per-stage control carried alongside each beat.
  typedef struct packed {
    logic valid;
    logic is_signed;
  } stage_ctrl_t;

  // Extend a w-bit operand (zero-padded into MAX_W bits) to 2*w bits:
  // sign-extension for two's-complement operands, zero-extension otherwise.
  // Bits above 2*w are always zero.
  function automatic logic [2*MAX_W-1:0] ext_operand(
    input logic [MAX_W-1:0] a,
    input int               w,
    input logic             is_signed
  );
    logic [2*MAX_W-1:0] ones;
    logic [2*MAX_W-1:0] lo_mask;
    logic [2*MAX_W-1:0] hi_mask;
    logic [MAX_W-1:0]   a_sh;
    logic               fill;
    ones    = '1;
    lo_mask = ~(ones << w);
    hi_mask = ~(ones << (2 * w)) & ~lo_mask;
    a_sh    = a >> (w - 1);
    fill    = is_signed & a_sh[0];
    return ({{MAX_W{1'b0}}, a} & lo_mask) | ({(2*MAX_W){fill}} & hi_mask);
  endfunction

endpackage

// File: rtl/mul_pp_sum.sv
// Combinational half of the partial-product array.
// HALF=0 sums partial products for multiplier bits [WIDTH/2-1:0];
// HALF=1 sums bits [WIDTH-1:WIDTH/2] and applies the negative weight of the
// multiplier sign bit when the beat is signed. All sums wrap mod 2^(2*WIDTH).
module mul_pp_sum
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HALF  = 0
) (
  input  logic [WIDTH-1:0]         i_a,
  input  logic [WIDTH/2-1:0]       i_b_half,
  input  logic                     i_signed,
  output logic [prod_w(WIDTH)-1:0] o_sum
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int HALF_W = WIDTH / 2;
  localparam int BASE   = HALF * HALF_W;

  logic [MAX_W-1:0]  w_a_max;
  logic [PROD_W-1:0] w_ext;
  logic [PROD_W-1:0] w_pp;

  assign w_a_max = MAX_W'(i_a);
  assign w_ext   = PROD_W'(ext_operand(w_a_max, WIDTH, i_signed));

  // Shift-and-add over this half's multiplier bits; top bit of a signed
  // multiplier carries weight -2^(WIDTH-1), hence the negation.
  always_comb begin
    o_sum = '0;
    w_pp  = '0;
    for (int i = 0; i < HALF_W; i++) begin
      w_pp = i_b_half[i] ? (w_ext << (BASE + i)) : '0;
      if ((HALF == 1) && (i == HALF_W - 1) && i_signed && i_b_half[i]) begin
        w_pp = -w_pp;
      end
      o_sum = o_sum + w_pp;
    end
  end

endmodule

// File: rtl/mul_pipe_hs.sv
// Three-stage pipelined WIDTH x WIDTH -> 2*WIDTH multiplier with per-beat
// signed/unsigned mode, valid/ready handshake on both sides and sync flush.
//   S1: operand register      S2: two half-sums of partial products
//   S3: final add -> out_prod
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. The producer holds in_valid and its data stable until the transfer;
// in_ready is a pure function of out_valid/out_ready and never looks at
// in_valid. Once out_valid is high, out_prod stays stable until out_ready.
// The whole pipe advances together, so a stalled output freezes every stage.
module mul_pipe_hs
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_w(WIDTH)-1:0] out_prod
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int HALF_W = WIDTH / 2;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (WIDTH > MAX_W)) begin : g_bad_width
    $error("mul_pipe_hs: WIDTH must be even, >= 4 and <= MAX_W");
  end

  // Pipeline control
  stage_ctrl_t       r_s1_ctrl;
  logic              r_s2_valid;
  logic              r_out_valid;

  // Pipeline data
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;
  logic [PROD_W-1:0] r_s2_lo;
  logic [PROD_W-1:0] r_s2_hi;
  logic [PROD_W-1:0] r_out_prod;

  logic              w_adv;
  logic [PROD_W-1:0] w_lo_sum;
  logic [PROD_W-1:0] w_hi_sum;

  // Pipe moves whenever the output slot is empty or being consumed.
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;

  mul_pp_sum #(.WIDTH(WIDTH), .HALF(0)) u_pp_lo (
    .i_a      (r_s1_a),
    .i_b_half (r_s1_b[HALF_W-1:0]),
    .i_signed (r_s1_ctrl.is_signed),
    .o_sum    (w_lo_sum)
  );

  mul_pp_sum #(.WIDTH(WIDTH), .HALF(1)) u_pp_hi (
    .i_a      (r_s1_a),
    .i_b_half (r_s1_b[WIDTH-1:HALF_W]),
    .i_signed (r_s1_ctrl.is_signed),
    .o_sum    (w_hi_sum)
  );

  // Stage valids and mode: flush clears valids only, otherwise shift on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_ctrl   <= '0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_s1_ctrl.valid <= 1'b0;
      r_s2_valid      <= 1'b0;
      r_out_valid     <= 1'b0;
    end else if (w_adv) begin
      r_s1_ctrl.valid <= in_valid;
      if (in_valid) begin
        r_s1_ctrl.is_signed <= in_signed;
      end
      r_s2_valid  <= r_s1_ctrl.valid;
      r_out_valid <= r_s2_valid;
    end
  end

  // Data registers load only behind a valid beat, so bubbles and flushes
  // leave them (and therefore out_prod) holding the last real value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_lo    <= '0;
      r_s2_hi    <= '0;
      r_out_prod <= '0;
    end else if (!flush && w_adv) begin
      if (in_valid) begin
        r_s1_a <= in_a;
        r_s1_b <= in_b;
      end
      if (r_s1_ctrl.valid) begin
        r_s2_lo <= w_lo_sum;
        r_s2_hi <= w_hi_sum;
      end
      if (r_s2_valid) begin
        r_out_prod <= r_s2_lo + r_s2_hi;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Bench for mul_pipe_hs: directed scenarios on an 8-bit instance and a
// randomized scoreboard run on a 16-bit instance.
module tb_mul_pipe_hs;

  logic clk;
  logic rst_n;

  logic        flush8, in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] out_prod8;

  logic        flush16, in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] out_prod16;

  int checks = 0;
  int errors = 0;
  int hs8_cnt = 0;
  int hs16_cnt = 0;

  logic [15:0] exp8_q[$];
  logic [31:0] exp16_q[$];

  mul_pipe_hs #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
    .in_a(a8), .in_b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_prod(out_prod8)
  );

  mul_pipe_hs #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush16),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_signed(in_signed16),
    .in_a(a16), .in_b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_prod(out_prod16)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference models ----------------
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = 16'($signed(a));
      sb = 16'($signed(b));
      return 16'(sa * sb);
    end
    return {8'd0, a} * {8'd0, b};
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sa, sb;
    if (s) begin
      sa = 32'($signed(a));
      sb = 32'($signed(b));
      return 32'(sa * sb);
    end
    return {16'd0, a} * {16'd0, b};
  endfunction

  // ---------------- scoreboards (sampled mid-cycle) ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      exp8_q.delete();
    end else begin
      if (out_valid8 && out_ready8) begin
        hs8_cnt++;
        checks++;
        if (exp8_q.size() == 0) begin
          errors++;
          $display("FAIL sb8_unexpected: got %h, no result outstanding", out_prod8);
        end else begin
          e = exp8_q.pop_front();
          if (out_prod8 !== e) begin
            errors++;
            $display("FAIL sb8_prod: got %h expected %h", out_prod8, e);
          end
        end
      end
      if (flush8) exp8_q.delete();
      else if (in_valid8 && in_ready8) exp8_q.push_back(model8(a8, b8, in_signed8));
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      exp16_q.delete();
    end else begin
      if (out_valid16 && out_ready16) begin
        hs16_cnt++;
        checks++;
        if (exp16_q.size() == 0) begin
          errors++;
          $display("FAIL sb16_unexpected: got %h, no result outstanding", out_prod16);
        end else begin
          e = exp16_q.pop_front();
          if (out_prod16 !== e) begin
            errors++;
            $display("FAIL sb16_prod: got %h expected %h", out_prod16, e);
          end
        end
      end
      if (flush16) exp16_q.delete();
      else if (in_valid16 && in_ready16) exp16_q.push_back(model16(a16, b16, in_signed16));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
    in_valid8  = 1'b1;
    a8         = a;
    b8         = b;
    in_signed8 = s;
  endtask

  // Returns the number of negedges waited until out_valid8, or -1 on timeout.
  task automatic wait_valid8(output int cyc);
    cyc = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid8 === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic drain8();
    in_valid8  = 1'b0;
    flush8     = 1'b0;
    out_ready8 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    flush8 = 0; in_valid8 = 0; in_signed8 = 0; a8 = 0; b8 = 0; out_ready8 = 1;
    flush16 = 0; in_valid16 = 0; in_signed16 = 0; a16 = 0; b16 = 0; out_ready16 = 1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b expected 0", out_valid8); end
    checks++; if (out_prod8 !== 16'h0) begin errors++; $display("FAIL reset_prod8: got %h expected 0000", out_prod8); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b expected 1", in_ready8); end
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL reset_valid16: got %b expected 0", out_valid16); end
    checks++; if (out_prod16 !== 32'h0) begin errors++; $display("FAIL reset_prod16: got %h expected 0", out_prod16); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    @(posedge clk); #1 drive8(8'hFF, 8'hFF, 1'b0);
    @(posedge clk); #1 in_valid8 = 1'b0;
    wait_valid8(cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2 (negedges after accept edge)", cyc); end
    checks++; if (out_prod8 !== 16'hFE01) begin errors++; $display("FAIL basic_prod: got %h expected FE01", out_prod8); end
    drain8();
  endtask

  task automatic test_signed();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic        ts [3];
    logic [15:0] te [3];
    int cyc;
    ta = '{8'h80, 8'hFF, 8'h80};
    tb = '{8'h80, 8'h7F, 8'h02};
    ts = '{1'b1, 1'b1, 1'b0};
    te = '{16'h4000, 16'hFF81, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 drive8(ta[i], tb[i], ts[i]);
      @(posedge clk); #1 in_valid8 = 1'b0;
      wait_valid8(cyc);
      checks++; if (cyc != 2) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 2", i, cyc); end
      checks++; if (out_prod8 !== te[i]) begin errors++; $display("FAIL signed_prod[%0d]: got %h expected %h", i, out_prod8, te[i]); end
      @(posedge clk); #1;
    end
    drain8();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic        ts [4];
    logic [15:0] te [4];
    logic        exp_v;
    ta = '{8'h03, 8'hFF, 8'h7F, 8'hC8};
    tb = '{8'h05, 8'h01, 8'h7F, 8'h0A};
    ts = '{1'b0, 1'b1, 1'b1, 1'b0};
    te = '{16'h000F, 16'hFFFF, 16'h3F01, 16'h07D0};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 4) drive8(ta[c], tb[c], ts[c]);
      else in_valid8 = 1'b0;
      @(negedge clk);
      exp_v = (c >= 3) && (c <= 6);
      checks++; if (out_valid8 !== exp_v) begin errors++; $display("FAIL b2b_valid[c%0d]: got %b expected %b", c, out_valid8, exp_v); end
      if (exp_v) begin
        checks++; if (out_prod8 !== te[c-3]) begin errors++; $display("FAIL b2b_prod[c%0d]: got %h expected %h", c, out_prod8, te[c-3]); end
      end
    end
    drain8();
  endtask

  task automatic test_backpressure();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic        ts [3];
    logic [15:0] te [3];
    int hs_start;
    ta = '{8'h12, 8'hF0, 8'hAB};
    tb = '{8'h34, 8'h10, 8'hCD};
    ts = '{1'b0, 1'b1, 1'b0};
    te = '{16'h03A8, 16'hFF00, 16'h88EF};
    hs_start = hs8_cnt;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 3) drive8(ta[c], tb[c], ts[c]);
      else in_valid8 = 1'b0;
      if (c == 3) out_ready8 = 1'b0;
      if (c == 8) out_ready8 = 1'b1;
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[c%0d]: got %b expected 0", c, in_ready8); end
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[c%0d]: got %b expected 1", c, out_valid8); end
        checks++; if (out_prod8 !== te[0]) begin errors++; $display("FAIL bp_stable[c%0d]: got %h expected %h", c, out_prod8, te[0]); end
      end else if (c >= 8 && c <= 10) begin
        checks++; if (out_prod8 !== te[c-8] || out_valid8 !== 1'b1) begin errors++; $display("FAIL bp_release[c%0d]: got v=%b %h expected v=1 %h", c, out_valid8, out_prod8, te[c-8]); end
      end else if (c == 11) begin
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL bp_tail_valid: got %b expected 0", out_valid8); end
      end
    end
    checks++; if (hs8_cnt - hs_start != 3) begin errors++; $display("FAIL bp_count: got %0d results expected 3", hs8_cnt - hs_start); end
    drain8();
  endtask

  task automatic test_flush();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       ts [3];
    int hs_start;
    int cyc;
    ta = '{8'h11, 8'h22, 8'h80};
    tb = '{8'h11, 8'h02, 8'h7F};
    ts = '{1'b0, 1'b0, 1'b1};
    hs_start = hs8_cnt;
    out_ready8 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      flush8 = 1'b0;
      if (c < 3) drive8(ta[c], tb[c], ts[c]);
      else if (c == 4) drive8(8'h05, 8'h05, 1'b0);
      else in_valid8 = 1'b0;
      if (c == 3 || c == 4) flush8 = 1'b1;
      if (c == 4) out_ready8 = 1'b1;
      @(negedge clk);
      if (c == 3) begin
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid8); end
      end
      if (c >= 4) begin
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL flush_valid[c%0d]: got %b expected 0", c, out_valid8); end
        checks++; if (out_prod8 !== 16'h0121) begin errors++; $display("FAIL flush_prod_hold[c%0d]: got %h expected 0121", c, out_prod8); end
      end
    end
    checks++; if (hs8_cnt != hs_start) begin errors++; $display("FAIL flush_leak: got %0d results expected 0", hs8_cnt - hs_start); end
    @(posedge clk); #1 drive8(8'h9C, 8'h9C, 1'b1);
    @(posedge clk); #1 in_valid8 = 1'b0;
    wait_valid8(cyc);
    checks++; if (cyc != 2 || out_prod8 !== 16'h2710) begin errors++; $display("FAIL flush_recover: got lat %0d %h expected lat 2 2710", cyc, out_prod8); end
    drain8();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 drive8(8'(8'h1F + c), 8'(8'h30 + c), 1'(c % 2));
    end
    checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid8); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid8); end
    checks++; if (out_prod8 !== 16'h0) begin errors++; $display("FAIL rstmid_prod: got %h expected 0000", out_prod8); end
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", out_valid8); end
    @(posedge clk); #1;
  endtask

  task automatic test_random16();
    int  sent = 0;
    int  cycles = 0;
    int  hs_start;
    logic acc;
    hs_start = hs16_cnt;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    while (sent < 10000 && cycles < 60000) begin
      if (!in_valid16 && $urandom_range(0, 3) != 0) begin
        in_valid16  = 1'b1;
        a16         = pick16();
        b16         = pick16();
        in_signed16 = 1'($urandom_range(0, 1));
      end
      out_ready16 = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid16 && in_ready16;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc) in_valid16 = 1'b0;
      cycles++;
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    checks++; if (sent != 10000) begin errors++; $display("FAIL rand16_sent: got %0d beats accepted expected 10000", sent); end
    for (int k = 0; k < 20 && exp16_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++; if (exp16_q.size() != 0) begin errors++; $display("FAIL rand16_drain: got %0d outstanding expected 0", exp16_q.size()); end
    checks++; if (hs16_cnt - hs_start != sent) begin errors++; $display("FAIL rand16_count: got %0d results expected %0d", hs16_cnt - hs_start, sent); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random16();
    checks++; if (exp8_q.size() != 0) begin errors++; $display("FAIL sb8_leftover: got %0d outstanding expected 0", exp8_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
